// File: rtl/instruction_loader_if.sv
// Byte-stream handshake plus instruction-RAM write port of the instruction loader.
// master = loader side, slave = byte source / RAM side.
interface instruction_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        iByte;
  logic              iByteValid;
  logic              oByteReady;
  logic              oWriteEnable;
  logic [ADDR_W-1:0] oWriteAddress;
  logic [27:0]       oInstruction;

  modport master (
    input  iByte, iByteValid,
    output oByteReady, oWriteEnable, oWriteAddress, oInstruction
  );

  modport slave (
    output iByte, iByteValid,
    input  oByteReady, oWriteEnable, oWriteAddress, oInstruction
  );
endinterface

// File: rtl/instruction_loader.sv
// Loads a length-prefixed byte stream into instruction RAM as 28-bit words, holding the core in reset meanwhile.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the core.
module instruction_loader #(
  parameter int MAX_WORDS = 256,
  parameter int ADDR_W    = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  instruction_loader_if.master bus,
  output logic                 oCpuReset,
  output logic                 oDone,
  output logic                 oError
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    CNT_HI, CNT_LO, B3, B2, B1, B0, CSUM, DONE, ERROR
  } state_t;
  localparam state_t AFTER_DATA = CSUM;
`else
  typedef enum logic [3:0] {
    CNT_HI, CNT_LO, B3, B2, B1, B0, DONE, ERROR
  } state_t;
  localparam state_t AFTER_DATA = DONE;
`endif

  localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [7:0]        count_hi_q, count_hi_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [19:0]       shift_q, shift_d;
  logic [27:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] n_words;

  assign accept  = bus.iByteValid && ready_q;
  assign n_words = {count_hi_q, bus.iByte};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    count_hi_d = count_hi_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    instr_d    = instr_q;
    wr_addr_d  = wr_addr_q;
    we_d       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      CNT_HI: if (accept) begin
        count_hi_d = bus.iByte;
        state_d    = CNT_LO;
      end
      CNT_LO: if (accept) begin
        count_d    = n_words;
        word_cnt_d = '0;
        if (n_words == 16'd0)                     state_d = AFTER_DATA;
        else if ({1'b0, n_words} > MAX_WORDS_W)   state_d = ERROR;
        else                                      state_d = B3;
      end
      B3: if (accept) begin
        // Only the low nibble of the first byte carries the opcode.
        if (bus.iByte[7:4] != 4'd0) begin
          state_d = ERROR;
        end else begin
          shift_d = {shift_q[11:0], bus.iByte};
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.iByte;
`endif
          state_d = B2;
        end
      end
      B2, B1: if (accept) begin
        shift_d = {shift_q[11:0], bus.iByte};
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q ^ bus.iByte;
`endif
        state_d = (state_q == B2) ? B1 : B0;
      end
      B0: if (accept) begin
        instr_d    = {shift_q, bus.iByte};
        wr_addr_d  = ADDR_W'(word_cnt_q);
        we_d       = 1'b1;
        word_cnt_d = word_cnt_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q ^ bus.iByte;
`endif
        state_d    = (word_cnt_q + 16'd1 == count_q) ? AFTER_DATA : B3;
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: if (accept) begin
        state_d = (bus.iByte == csum_q) ? DONE : ERROR;
      end
`endif
      DONE, ERROR: if (iStart) begin
        state_d    = CNT_HI;
        wr_addr_d  = '0;
        word_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = '0;
`endif
      end
      default: state_d = ERROR;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ready_d   = (state_d != DONE) && (state_d != ERROR);
    cpu_rst_d = (state_d != DONE);
    done_d    = (state_d == DONE);
    error_d   = (state_d == ERROR);
  end

  always_ff @(posedge Clock) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!Reset) begin
      state_q    <= CNT_HI;
      count_hi_q <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      instr_q    <= '0;
      wr_addr_q  <= '0;
      we_q       <= 1'b0;
      ready_q    <= 1'b1;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_hi_q <= count_hi_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      instr_q    <= instr_d;
      wr_addr_q  <= wr_addr_d;
      we_q       <= we_d;
      ready_q    <= ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.oByteReady    = ready_q;
  assign bus.oWriteEnable  = we_q;
  assign bus.oWriteAddress = wr_addr_q;
  assign bus.oInstruction  = instr_q;
  assign oCpuReset         = cpu_rst_q;
  assign oDone             = done_q;
  assign oError            = error_q;

endmodule
